interleaver_commutator: RTL and testbench

INTERLEAVER_COMMUTATOR -- requirements
Module: interleaver_commutator

---
 rtl/intlv_pkg.sv | 27 ++
 rtl/intlv_branch_ctr.sv | 40 ++++
 rtl/interleaver_commutator.sv | 169 ++++++++++++++++
 tb/tb_interleaver_commutator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/intlv_pkg.sv
// Shared definitions for the convolutional interleaver commutator.
//   intlv_state_t  : commutator state encoding (IDLE, FILL, RUN)
//   NUM_BRANCH_DEF : default number of interleaver branches
//   UNIT_DEPTH_DEF : default per-branch delay increment, in enabled bytes
//   fill_target()  : bytes that must be accepted before every delay line
//                    holds valid data
package intlv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } intlv_state_t;

    localparam int NUM_BRANCH_DEF = 12;
    localparam int UNIT_DEPTH_DEF = 17;

    // Branch i holds i*UNIT_DEPTH bytes and is written once every NUM_BRANCH
    // accepted bytes, so the deepest branch is full after
    // UNIT_DEPTH*(NUM_BRANCH-1)*NUM_BRANCH accepted bytes.
    function automatic int fill_target(input int unit_depth, input int num_branch);
        return unit_depth * num_branch * (num_branch - 1);
    endfunction

    localparam int FILL_TARGET_DEF = fill_target(UNIT_DEPTH_DEF, NUM_BRANCH_DEF);

endpackage

// File: rtl/intlv_branch_ctr.sv
// Branch index counter for the interleaver commutator.
//   clk     : clock
//   reset   : asynchronous active-low reset, clears idx to 0
//   advance : one byte accepted this cycle; idx steps by one, wrapping
//             NUM_BRANCH-1 -> 0
//   realign : the accepted byte was a misaligned sync taken as branch 0,
//             so the next byte belongs to branch 1
//   idx     : current branch index
module intlv_branch_ctr
    import intlv_pkg::*;
#(
    parameter int NUM_BRANCH = NUM_BRANCH_DEF,
    parameter int IDX_W      = $clog2(NUM_BRANCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             realign,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] idx_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_reg <= '0;
        end else if (realign) begin
            idx_reg <= IDX_W'(1);
        end else if (advance) begin
            if (idx_reg == IDX_W'(NUM_BRANCH - 1)) begin
                idx_reg <= '0;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign idx = idx_reg;

endmodule

// File: rtl/interleaver_commutator.sv
// Convolutional interleaver commutator. Steers each accepted byte to one of
// NUM_BRANCH external delay buffers (branch 0 has no delay) and collects the
// interleaved byte from the selected buffer tail one cycle later.
//   clk         : clock
//   reset       : asynchronous active-low reset
//   in_valid    : in_data carries a byte
//   in_data     : byte stream from the packetiser
//   in_sync     : in_data is a packet sync byte (qualified by in_valid)
//   branch_dout : tail bytes of branch buffers, slice i = branch i
//                 (slice 0 unused, branch 0 passes in_data straight through)
//   branch_en   : one-hot write enable to branch buffers, bit 0 always 0
//   branch_din  : common write data for all branch buffers
//   out_valid   : out_data valid
//   out_data    : interleaved byte
//   out_sync    : out_data is a branch-0 sync byte
//   sync_err    : one-cycle pulse after a sync arrived off branch 0
// Build option: define INTLV_WARMUP_EN to suppress out_valid until every
// delay buffer has been filled (state RUN).
module interleaver_commutator
    import intlv_pkg::*;
#(
    parameter int NUM_BRANCH = NUM_BRANCH_DEF,
    parameter int DATA_W     = 8,
    parameter int UNIT_DEPTH = UNIT_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_sync,
    input  logic [NUM_BRANCH*DATA_W-1:0] branch_dout,
    output logic [NUM_BRANCH-1:0]        branch_en,
    output logic [DATA_W-1:0]            branch_din,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_sync,
    output logic                         sync_err
);

    localparam int IDX_W    = $clog2(NUM_BRANCH);
    localparam int FILL_TGT = fill_target(UNIT_DEPTH, NUM_BRANCH);
    localparam int CNT_W    = $clog2(FILL_TGT) + 1;

    intlv_state_t      state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  eff_idx;
    logic              accept;
    logic              realign;
    logic              valid_cond;

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_sync_reg;
    logic              sync_err_reg;

    logic [DATA_W-1:0] tail [NUM_BRANCH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BRANCH; gi++) begin : g_tail
            assign tail[gi] = branch_dout[gi*DATA_W +: DATA_W];
        end
    endgenerate

    intlv_branch_ctr #(
        .NUM_BRANCH (NUM_BRANCH),
        .IDX_W      (IDX_W)
    ) u_branch_ctr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .realign (realign),
        .idx     (idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        realign    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Only a sync byte leaves IDLE; it is branch 0 and the
                // first byte of the fill.
                if (in_valid && in_sync) begin
                    accept     = 1'b1;
                    state_next = FILL;
                    cnt_next   = CNT_W'(1);
                end
            end
            FILL, RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_sync && (idx != '0)) begin
                        // Lost alignment: take this sync as branch 0 and
                        // restart the fill with it as the first byte.
                        realign    = 1'b1;
                        state_next = FILL;
                        cnt_next   = CNT_W'(1);
                    end else if (state_reg == FILL) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(FILL_TGT - 1)) begin
                            state_next = RUN;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A realigning sync byte is steered as branch 0 regardless of idx.
    assign eff_idx = realign ? '0 : idx;

    assign branch_en[0] = 1'b0;
    generate
        for (gi = 1; gi < NUM_BRANCH; gi++) begin : g_en
            assign branch_en[gi] = accept && (state_reg != IDLE)
                                   && (eff_idx == IDX_W'(gi));
        end
    endgenerate

    assign branch_din = in_data;

`ifdef INTLV_WARMUP_EN
    assign valid_cond = (state_reg == RUN);
`else
    assign valid_cond = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sync_reg  <= 1'b0;
            sync_err_reg  <= 1'b0;
        end else begin
            sync_err_reg <= realign;
            if (accept) begin
                out_valid_reg <= valid_cond;
                out_sync_reg  <= in_sync && valid_cond;
                out_data_reg  <= (eff_idx == '0) ? in_data : tail[eff_idx];
            end else begin
                out_valid_reg <= 1'b0;
                out_sync_reg  <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sync  = out_sync_reg;
    assign sync_err  = sync_err_reg;

endmodule

// File: tb/tb_interleaver_commutator.sv
module tb_interleaver_commutator;
    import intlv_pkg::*;

`ifdef INTLV_WARMUP_EN
    localparam bit WARM = 1'b1;
`else
    localparam bit WARM = 1'b0;
`endif
    // out_valid expected for a byte accepted during FILL
    localparam logic FV = WARM ? 1'b0 : 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sync = 1'b0;
    logic [95:0] branch_dout;
    logic [11:0] branch_en;
    logic [7:0]  branch_din;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sync;
    logic        sync_err;

    int total = 0;
    int bad = 0;
    logic [11:0] en_obs;

    interleaver_commutator dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sync     (in_sync),
        .branch_dout (branch_dout),
        .branch_en   (branch_en),
        .branch_din  (branch_din),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sync    (out_sync),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // One accepted-byte transaction: inputs set at negedge, enables sampled
    // combinationally, registered outputs sampled 1 time unit after posedge.
    task automatic drive(input logic [7:0] d, input logic s, input bit quiet);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sync  = s;
        #1 en_obs = branch_en;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        if (!quiet)
            $display("txn data=%h sync=%b en=%h out_valid=%b out_data=%h out_sync=%b sync_err=%b",
                     d, s, en_obs, out_valid, out_data, out_sync, sync_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h11;
        #12;
        total++; if (branch_en !== 12'h000) begin bad++; $display("FAIL rst_en got=%h exp=000", branch_en); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", out_data); end
        total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dut.state_reg, IDLE); end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(8'h22, 1'b0, 1'b0);
        total++; if (en_obs !== 12'h000) begin bad++; $display("FAIL idle_en got=%h exp=000", en_obs); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
        total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL idle_state got=%0d exp=%0d", dut.state_reg, IDLE); end
    endtask

    task automatic test_branch_seq();
        logic [11:0] exp_en;
        logic [7:0]  exp_d;
        do_reset();
        drive(8'h47, 1'b1, 1'b0);
        total++; if (en_obs !== 12'h000) begin bad++; $display("FAIL seq_en0 got=%h exp=000", en_obs); end
        total++; if (out_valid !== FV) begin bad++; $display("FAIL seq_valid0 got=%b exp=%b", out_valid, FV); end
        total++; if (out_data !== 8'h47) begin bad++; $display("FAIL seq_data0 got=%h exp=47", out_data); end
        total++; if (out_sync !== FV) begin bad++; $display("FAIL seq_sync0 got=%b exp=%b", out_sync, FV); end
        total++; if (dut.state_reg !== FILL) begin bad++; $display("FAIL seq_state got=%0d exp=%0d", dut.state_reg, FILL); end
        for (int k = 1; k < 12; k++) begin
            exp_en = 12'h001 << k;
            exp_d  = 8'hA0 + 8'(k);
            drive(8'(k), 1'b0, 1'b0);
            total++; if (en_obs !== exp_en) begin bad++; $display("FAIL seq_en%0d got=%h exp=%h", k, en_obs, exp_en); end
            total++; if (out_data !== exp_d) begin bad++; $display("FAIL seq_data%0d got=%h exp=%h", k, out_data, exp_d); end
            total++; if (out_sync !== 1'b0) begin bad++; $display("FAIL seq_sync%0d got=%b exp=0", k, out_sync); end
        end
        // wrapped back to branch 0: aligned sync, no error
        drive(8'h47, 1'b1, 1'b0);
        total++; if (en_obs !== 12'h000) begin bad++; $display("FAIL wrap_en got=%h exp=000", en_obs); end
        total++; if (out_data !== 8'h47) begin bad++; $display("FAIL wrap_data got=%h exp=47", out_data); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", sync_err); end
        total++; if (dut.state_reg !== FILL) begin bad++; $display("FAIL wrap_state got=%0d exp=%0d", dut.state_reg, FILL); end
    endtask

    // Fill to RUN, then misalign a sync at branch 5.
    task automatic test_fill_run_misalign();
        do_reset();
        drive(8'h47, 1'b1, 1'b1);
        for (int n = 2; n <= 2243; n++) begin
            drive(8'(n), 1'b0, 1'b1);
            total++; if (out_valid !== FV) begin bad++; $display("FAIL fill_valid byte=%0d got=%b exp=%b", n, out_valid, FV); end
        end
        total++; if (dut.state_reg !== FILL) begin bad++; $display("FAIL fill_state2243 got=%0d exp=%0d", dut.state_reg, FILL); end
        drive(8'hC4, 1'b0, 1'b0);  // byte 2244, branch 11, last FILL byte
        total++; if (out_valid !== FV) begin bad++; $display("FAIL fill_valid2244 got=%b exp=%b", out_valid, FV); end
        total++; if (en_obs !== 12'h800) begin bad++; $display("FAIL fill_en2244 got=%h exp=800", en_obs); end
        total++; if (dut.state_reg !== RUN) begin bad++; $display("FAIL run_state got=%0d exp=%0d", dut.state_reg, RUN); end
        drive(8'h5A, 1'b0, 1'b0);  // byte 2245, branch 0, first RUN byte
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL run_valid2245 got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'h5A) begin bad++; $display("FAIL run_data2245 got=%h exp=5A", out_data); end
        for (int k = 1; k <= 4; k++) drive(8'h60 + 8'(k), 1'b0, 1'b0);
        total++; if (en_obs !== 12'h010) begin bad++; $display("FAIL run_en4 got=%h exp=010", en_obs); end
        total++; if (out_data !== 8'hA4) begin bad++; $display("FAIL run_data4 got=%h exp=A4", out_data); end
        drive(8'h47, 1'b1, 1'b0);  // sync arriving at branch 5
        total++; if (en_obs !== 12'h000) begin bad++; $display("FAIL mis_en got=%h exp=000", en_obs); end
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", sync_err); end
        total++; if (out_data !== 8'h47) begin bad++; $display("FAIL mis_data got=%h exp=47", out_data); end
        total++; if (out_sync !== 1'b1) begin bad++; $display("FAIL mis_sync got=%b exp=1", out_sync); end
        total++; if (dut.state_reg !== FILL) begin bad++; $display("FAIL mis_state got=%0d exp=%0d", dut.state_reg, FILL); end
        drive(8'h31, 1'b0, 1'b0);
        total++; if (en_obs !== 12'h002) begin bad++; $display("FAIL mis_next_en got=%h exp=002", en_obs); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL mis_err_clr got=%b exp=0", sync_err); end
        total++; if (out_data !== 8'hA1) begin bad++; $display("FAIL mis_next_data got=%h exp=A1", out_data); end
    endtask

    // Continues from branch 2 after the realignment above.
    task automatic test_gaps();
        logic [11:0] exp_en;
        logic [7:0]  exp_d;
        for (int r = 0; r < 3; r++) begin
            exp_en = 12'h004 << r;
            exp_d  = 8'hA2 + 8'(r);
            drive(8'h33 + 8'(r), 1'b0, 1'b0);
            total++; if (en_obs !== exp_en) begin bad++; $display("FAIL gap_en%0d got=%h exp=%h", r, en_obs, exp_en); end
            total++; if (out_data !== exp_d) begin bad++; $display("FAIL gap_data%0d got=%h exp=%h", r, out_data, exp_d); end
            for (int g = 0; g < 3; g++) begin
                @(posedge clk);
                #1;
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_valid r=%0d g=%0d got=%b exp=0", r, g, out_valid); end
                total++; if (branch_en !== 12'h000) begin bad++; $display("FAIL gap_en r=%0d g=%0d got=%h exp=000", r, g, branch_en); end
            end
            total++; if (out_data !== exp_d) begin bad++; $display("FAIL gap_hold%0d got=%h exp=%h", r, out_data, exp_d); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(8'h47, 1'b1, 1'b1);
        for (int n = 2; n <= 999; n++) drive(8'(n), 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h77;
        #2 reset = 1'b0;
        #1;
        total++; if (branch_en !== 12'h000) begin bad++; $display("FAIL mr_en got=%h exp=000", branch_en); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL mr_data got=%h exp=00", out_data); end
        total++; if (out_sync !== 1'b0) begin bad++; $display("FAIL mr_sync got=%b exp=0", out_sync); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL mr_err got=%b exp=0", sync_err); end
        total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL mr_state got=%0d exp=%0d", dut.state_reg, IDLE); end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(8'h12, 1'b0, 1'b0);
        total++; if (en_obs !== 12'h000) begin bad++; $display("FAIL mr_nosync_en got=%h exp=000", en_obs); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_nosync_valid got=%b exp=0", out_valid); end
        drive(8'h47, 1'b1, 1'b0);
        total++; if (out_valid !== FV) begin bad++; $display("FAIL mr_sync_valid got=%b exp=%b", out_valid, FV); end
        total++; if (dut.state_reg !== FILL) begin bad++; $display("FAIL mr_restart got=%0d exp=%0d", dut.state_reg, FILL); end
        drive(8'h13, 1'b0, 1'b0);
        total++; if (en_obs !== 12'h002) begin bad++; $display("FAIL mr_next_en got=%h exp=002", en_obs); end
        total++; if (branch_din !== 8'h00 && branch_din !== 8'h13) begin bad++; $display("FAIL mr_din got=%h exp=13", branch_din); end
    endtask

    initial begin
        for (int i = 0; i < 12; i++) branch_dout[i*8 +: 8] = 8'hA0 + 8'(i);
        test_reset();
        test_branch_seq();
        test_fill_run_misalign();
        test_gaps();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
